// File: rtl/uart_rx_if.sv
// Byte-side bundle of the UART receiver: received byte, valid strobe,
// busy indication and framing-error strobe.
interface uart_rx_if;
    logic       o_rx_dv;
    logic [7:0] o_rx_byte;
    logic       o_rx_act;
    logic       o_rx_frame_err;

    modport master (
        output o_rx_dv,
        output o_rx_byte,
        output o_rx_act,
        output o_rx_frame_err
    );

    modport slave (
        input o_rx_dv,
        input o_rx_byte,
        input o_rx_act,
        input o_rx_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1, oversampled at CLKS_PER_BIT clocks per bit with
// mid-bit sampling; reports good bytes and stop-bit framing errors.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_rx_serial,
    uart_rx_if.master rx
);

    localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam logic [7:0]  HALF_CNT = 8'(HALF_BIT);
    localparam logic [7:0]  BIT_END  = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_CLEANUP   = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] clk_cnt_r;
    logic [7:0] clk_cnt_nxt_s;
    logic [2:0] bit_idx_r;
    logic [2:0] bit_idx_nxt_s;
    logic [7:0] shift_r;
    logic [7:0] shift_nxt_s;
    logic       rx_meta_r;
    logic       rx_s;

    logic       dv_r;
    logic [7:0] byte_r;
    logic       act_r;
    logic       frame_err_r;

    // Two-flop synchronizer for the asynchronous serial line (idle high).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= i_rx_serial;
            rx_s      <= rx_meta_r;
        end
    end

    // FSM state, bit counter, bit index and shift register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= 8'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            clk_cnt_r <= clk_cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Next-state logic: mid-bit start re-check, then full-bit spacing.
    always_comb begin
        state_nxt_s   = state_r;
        clk_cnt_nxt_s = clk_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        case (state_r)
            ST_IDLE: begin
                clk_cnt_nxt_s = 8'd0;
                bit_idx_nxt_s = 3'd0;
                if (!rx_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_cnt_r == HALF_CNT) begin
                    clk_cnt_nxt_s = 8'd0;
                    // A line back high at mid-start was a glitch, not a frame.
                    if (!rx_s) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 8'd1;
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == BIT_END) begin
                    clk_cnt_nxt_s          = 8'd0;
                    shift_nxt_s[bit_idx_r] = rx_s;
                    if (bit_idx_r != 3'd7) begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end else begin
                        bit_idx_nxt_s = 3'd0;
                        state_nxt_s   = ST_STOP;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 8'd1;
                end
            end
            ST_STOP: begin
                if (clk_cnt_r == BIT_END) begin
                    clk_cnt_nxt_s = 8'd0;
                    if (rx_s) begin
                        state_nxt_s = ST_CLEANUP;
                    end else begin
                        state_nxt_s = ST_WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 8'd1;
                end
            end
            ST_CLEANUP: begin
                clk_cnt_nxt_s = 8'd0;
                state_nxt_s   = ST_IDLE;
            end
            ST_WAIT_IDLE: begin
                // clk_cnt_r == 0 only on the first cycle here; it marks the error pulse.
                if (rx_s) begin
                    clk_cnt_nxt_s = 8'd0;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    clk_cnt_nxt_s = 8'd1;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clk_cnt_nxt_s = 8'd0;
                bit_idx_nxt_s = 3'd0;
            end
        endcase
    end

    // Output registers, decoded from the current state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dv_r        <= 1'b0;
            byte_r      <= 8'd0;
            act_r       <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            dv_r        <= (state_r == ST_CLEANUP);
            act_r       <= (state_r == ST_START) || (state_r == ST_DATA) ||
                           (state_r == ST_STOP);
            frame_err_r <= (state_r == ST_WAIT_IDLE) && (clk_cnt_r == 8'd0);
            if (state_r == ST_CLEANUP) begin
                byte_r <= shift_r;
            end else begin
                byte_r <= byte_r;
            end
        end
    end

    assign rx.o_rx_dv        = dv_r;
    assign rx.o_rx_byte      = byte_r;
    assign rx.o_rx_act       = act_r;
    assign rx.o_rx_frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_rx_serial = 1'b1;

    uart_rx_if rx_bus ();

    uart_rx #(.CLKS_PER_BIT(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_serial (i_rx_serial),
        .rx          (rx_bus)
    );

    always #5 i_clk = ~i_clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_byte = 8'h00;
    int         dv_seen;
    int         err_seen;
    int         act_seen;
    int         first_err;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 8'h%02h expected 8'h%02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called 1 ns after edge E0; the frame's first sync capture is edge E0+1 (= k),
    // so the result strobe belongs on edge E0+80 (= k+79).
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl);
        i_rx_serial = 1'b0;
        @(posedge i_clk); #1;
        check1("dv_low_at_start", rx_bus.o_rx_dv, 1'b0);
        repeat (2) @(posedge i_clk); #1;
        check1("act_low_k2", rx_bus.o_rx_act, 1'b0);
        @(posedge i_clk); #1;
        check1("act_high_k3", rx_bus.o_rx_act, 1'b1);
        repeat (4) @(posedge i_clk); #1;
        for (int i = 0; i < 8; i++) begin
            i_rx_serial = data[i];
            repeat (8) @(posedge i_clk); #1;
        end
        i_rx_serial = stop_lvl;
        repeat (7) @(posedge i_clk); #1;
        check1("dv_low_k78", rx_bus.o_rx_dv, 1'b0);
        check1("err_low_k78", rx_bus.o_rx_frame_err, 1'b0);
        check1("act_high_k78", rx_bus.o_rx_act, 1'b1);
        @(posedge i_clk); #1;
        if (stop_lvl) begin
            exp_byte = data;
        end
        check1("dv_k79", rx_bus.o_rx_dv, stop_lvl);
        check1("err_k79", rx_bus.o_rx_frame_err, ~stop_lvl);
        check1("act_low_k79", rx_bus.o_rx_act, 1'b0);
        check8("byte_k79", rx_bus.o_rx_byte, exp_byte);
    endtask

    initial begin
        // Reset and idle line
        repeat (3) @(posedge i_clk);
        #1;
        check1("rst_dv", rx_bus.o_rx_dv, 1'b0);
        check8("rst_byte", rx_bus.o_rx_byte, 8'h00);
        check1("rst_act", rx_bus.o_rx_act, 1'b0);
        check1("rst_err", rx_bus.o_rx_frame_err, 1'b0);
        #2 i_rst = 1'b0;
        act_seen = 0; dv_seen = 0; err_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_clk); #1;
            act_seen += int'(rx_bus.o_rx_act);
            dv_seen  += int'(rx_bus.o_rx_dv);
            err_seen += int'(rx_bus.o_rx_frame_err);
        end
        check_int("idle_act", act_seen, 0);
        check_int("idle_dv", dv_seen, 0);
        check_int("idle_err", err_seen, 0);
        check8("idle_byte", rx_bus.o_rx_byte, 8'h00);

        // Single frame 0xA5
        send_frame(8'hA5, 1'b1);
        repeat (10) @(posedge i_clk); #1;

        // Back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (10) @(posedge i_clk); #1;

        // Two-clock glitch on an idle line
        i_rx_serial = 1'b0;
        repeat (2) @(posedge i_clk); #1;
        i_rx_serial = 1'b1;
        dv_seen = 0; err_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge i_clk); #1;
            dv_seen  += int'(rx_bus.o_rx_dv);
            err_seen += int'(rx_bus.o_rx_frame_err);
        end
        check_int("glitch_dv", dv_seen, 0);
        check_int("glitch_err", err_seen, 0);
        check1("glitch_act", rx_bus.o_rx_act, 1'b0);
        check8("glitch_byte", rx_bus.o_rx_byte, 8'hFF);

        // Framing error: stop bit low, line held low 40 more clocks
        send_frame(8'h3C, 1'b0);
        dv_seen = 0; err_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk); #1;
            dv_seen  += int'(rx_bus.o_rx_dv);
            err_seen += int'(rx_bus.o_rx_frame_err);
        end
        check_int("break_extra_err", err_seen, 0);
        check_int("break_dv", dv_seen, 0);
        check8("break_byte", rx_bus.o_rx_byte, 8'hFF);
        i_rx_serial = 1'b1;
        repeat (20) @(posedge i_clk); #1;
        send_frame(8'h5A, 1'b1);
        repeat (10) @(posedge i_clk); #1;

        // Reset asserted during data bit 4 of 0x81
        i_rx_serial = 1'b0;
        repeat (8) @(posedge i_clk); #1;
        for (int i = 0; i < 4; i++) begin
            i_rx_serial = (i == 0) ? 1'b1 : 1'b0;
            repeat (8) @(posedge i_clk); #1;
        end
        i_rx_serial = 1'b0;
        repeat (3) @(posedge i_clk);
        #3 i_rst = 1'b1;
        #1;
        exp_byte = 8'h00;
        check1("midrst_dv", rx_bus.o_rx_dv, 1'b0);
        check8("midrst_byte", rx_bus.o_rx_byte, 8'h00);
        check1("midrst_act", rx_bus.o_rx_act, 1'b0);
        check1("midrst_err", rx_bus.o_rx_frame_err, 1'b0);
        i_rx_serial = 1'b1;
        repeat (3) @(posedge i_clk);
        #3 i_rst = 1'b0;
        dv_seen = 0; err_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk); #1;
            dv_seen  += int'(rx_bus.o_rx_dv);
            err_seen += int'(rx_bus.o_rx_frame_err);
        end
        check_int("postrst_dv", dv_seen, 0);
        check_int("postrst_err", err_seen, 0);
        send_frame(8'h81, 1'b1);
        repeat (10) @(posedge i_clk); #1;

        // Line held low out of reset: one framing error at k+79, no byte
        i_rst = 1'b1;
        i_rx_serial = 1'b0;
        @(posedge i_clk);
        #3 i_rst = 1'b0;
        dv_seen = 0; err_seen = 0; first_err = 0;
        for (int i = 1; i <= 120; i++) begin
            @(posedge i_clk); #1;
            if (rx_bus.o_rx_frame_err && (first_err == 0)) begin
                first_err = i;
            end
            dv_seen  += int'(rx_bus.o_rx_dv);
            err_seen += int'(rx_bus.o_rx_frame_err);
        end
        check_int("lowrst_err_edge", first_err, 80);
        check_int("lowrst_err_count", err_seen, 1);
        check_int("lowrst_dv", dv_seen, 0);
        check8("lowrst_byte", rx_bus.o_rx_byte, 8'h00);
        i_rx_serial = 1'b1;
        repeat (10) @(posedge i_clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
